md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit in stage E of the 5-stage MIPS pipeline; owns HI/LO.
//  Runs MULT/MULTU/DIV/DIVU as multi-cycle ops and exports busy.
//  The hazard/stall unit freezes IFU/F2D/D2E and flushes D2E while an MD-class
//  instruction sits in D and (start|busy).
//  Also serves MFHI/MFLO reads and MTHI/MTLO writes.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk    in   1   pipeline clock; all state changes on posedge
//  reset  in   1   synchronous, active-high; clears all state
//  start  in   1   E-stage MD instruction valid this cycle (already un-flushed)
//  op     in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//  A      in   32  forwarded rs value (E stage)
//  B      in   32  forwarded rt value (E stage)
//  busy   out  1   registered; 1 while a mult/div is in flight
//  HI     out  32  registered HI register
//  LO     out  32  registered LO register
//  rd     out  32  combinational: op==MFHI ? HI : op==MFLO ? LO : 0
// BEHAVIOUR
//  Reset: busy=0, HI=0, LO=0, counter=0, operand/result latches=0, state IDLE.
//   Reset wins over every other input, including mid-operation:
//   an in-flight op is discarded and HI/LO are not written.
//  FSM states:
//   IDLE: on posedge with start=1 and op in 1..4:
//    - latch A, B, op;
//    - cnt <= (op<=2 ? MULT_CYCLES : DIV_CYCLES);
//    - busy <= 1; go RUN.
//    start with op 7/8: HI<=A (MTHI) / LO<=A (MTLO) at that edge; stay IDLE.
//    op 0, 5, 6: no state change.
//   RUN: each posedge cnt <= cnt-1.
//    When cnt==1 at a posedge: commit result to HI/LO, busy <= 0, go IDLE.
//    Net: busy high for exactly N cycles after the start edge.
//    HI/LO hold the new value from the edge that drops busy.
//  start asserted while busy=1: ignored entirely (latches, HI/LO, cnt untouched).
//   The stall unit guarantees this does not occur; the bench still checks it.
//  Arithmetic, computed from latched operands:
//   MULT  : {HI,LO} = $signed(A) * $signed(B), full 64-bit.
//   MULTU : {HI,LO} = A * B unsigned, full 64-bit.
//   DIV   : LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//   DIVU  : unsigned quotient/remainder.
//   DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
//   Divide by zero (B==0, DIV or DIVU): op still takes DIV_CYCLES, busy behaves
//    normally, HI and LO unchanged at commit.
//  rd is purely combinational on op and current HI/LO.
//   MFHI in the same cycle as the committing edge reads the pre-commit value.
//   The stall unit prevents that case.
//  MTHI/MTLO and commit never coincide (MT* ignored while busy).
// TESTING
//  1. reset=1 for 2 cycles -> busy=0, HI=0, LO=0, rd=0.
//  2. MULT A=0xFFFFFFFF B=2 start 1 cycle:
//     -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//     Repeat with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
//  3. DIV A=-7 B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU A=7 B=2 -> LO=3, HI=1.
//     DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. Preload HI=0x11, LO=0x22 via MTHI/MTLO; then DIVU A=7 B=0:
//     -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
//     op=MFHI -> rd=0x11; op=MFLO -> rd=0x22.
//  5. Start MULT, pulse start with MTLO A=0x55 on busy cycle 2:
//     -> ignored; final LO = product, busy timing unchanged.
//  6. Start DIV, assert reset on busy cycle 4 -> next cycle busy=0, HI=LO=0;
//     a new MULT then completes normally with its own count.

Source files
------------

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage multiply/divide unit port bundle
interface md_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd;

    modport master (output start, op, A, B, input busy, HI, LO, rd);
    modport slave  (input start, op, A, B, output busy, HI, LO, rd);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MULT/DIV unit owning HI/LO
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0] sq_mag, sr_mag, q_s, r_s, q_u, r_u;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'h0, a_q} * {32'h0, b_q};
        a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
        sq_mag     = a_mag / b_mag_safe;
        sr_mag     = a_mag % b_mag_safe;
        q_s        = (a_q[31] ^ b_q[31]) ? (~sq_mag + 32'd1) : sq_mag;
        r_s        = a_q[31] ? (~sr_mag + 32'd1) : sr_mag;
        q_u        = a_q / b_safe;
        r_u        = a_q % b_safe;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    if (md.op >= OP_MULT && md.op <= OP_DIVU) begin
                        a_d     = md.A;
                        b_d     = md.B;
                        op_d    = md.op;
                        cnt_d   = (md.op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (md.op == OP_MTHI) begin
                        hi_d = md.A;
                    end else if (md.op == OP_MTLO) begin
                        lo_d = md.A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV:   if (b_q != 32'd0) begin lo_d = q_s; hi_d = r_s; end
                        OP_DIVU:  if (b_q != 32'd0) begin lo_d = q_u; hi_d = r_u; end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
    assign md.rd   = (md.op == OP_MFHI) ? hi_q : (md.op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with a longint reference model
module tb_md_unit;
    logic clk;
    logic reset;
    md_unit_if md ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m = 0;
    logic [31:0] lo_m = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural rules.
    task automatic model(logic [3:0] o, logic [31:0] a, logic [31:0] b, output exp_t e);
        int              ia, ib;
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
        case (o)
            4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            4'd2: begin up = ua * ub; hi_m = up[63:32]; lo_m = up[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            4'd4: if (b != 0) begin up = ua / ub; lo_m = up[31:0]; up = ua % ub; hi_m = up[31:0]; end
            default: ;
        endcase
        e.hi  = hi_m;
        e.lo  = lo_m;
        e.cyc = (o <= 4'd2) ? 5 : 10;
    endtask

    task automatic issue(logic [3:0] o, logic [31:0] a, logic [31:0] b);
        exp_t e;
        @(posedge clk); #1;
        md.start = 1'b1; md.op = o; md.A = a; md.B = b;
        if (o >= 4'd1 && o <= 4'd4) begin
            model(o, a, b, e);
            sb_q.push_back(e);
        end else if (o == 4'd7) hi_m = a;
        else if (o == 4'd8) lo_m = a;
        @(posedge clk); #1;
        md.start = 1'b0; md.op = 4'd0;
        if (o == 4'd7) check("mthi", md.HI, hi_m);
        if (o == 4'd8) check("mtlo", md.LO, lo_m);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (md.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", {31'b0, md.busy}, 32'd0);
    endtask

    task automatic check_rd();
        md.op = 4'd5; #1; check("rd_mfhi", md.rd, hi_m);
        md.op = 4'd6; #1; check("rd_mflo", md.rd, lo_m);
        md.op = 4'd0; #1; check("rd_none", md.rd, 32'd0);
    endtask

    task automatic directed(logic [3:0] o, logic [31:0] a, logic [31:0] b,
                            logic [31:0] ehi, logic [31:0] elo);
        issue(o, a, b);
        wait_idle();
        check("dir_hi", md.HI, ehi);
        check("dir_lo", md.LO, elo);
    endtask

    // Monitor: every busy fall outside reset is a commit to be scored.
    initial begin
        int   busy_cnt = 0;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (md.busy) busy_cnt++;
                else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_commit actual=1 required=0");
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_hi", md.HI, e.hi);
                        check("sb_lo", md.LO, e.lo);
                        check("sb_busy_cycles", busy_cnt, e.cyc);
                    end
                    busy_cnt = 0;
                end
                prev_busy = md.busy;
            end
        end
    end

    initial begin
        logic [3:0]  ops[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        logic [3:0]  o;
        logic [31:0] a, b;
        reset = 1'b1; md.start = 1'b0; md.op = 4'd0; md.A = 0; md.B = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, md.busy}, 32'd0);
        check("rst_hi", md.HI, 32'd0);
        check("rst_lo", md.LO, 32'd0);
        check("rst_rd", md.rd, 32'd0);
        reset = 1'b0;

        directed(4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        directed(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        directed(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        directed(4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        directed(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        issue(4'd7, 32'h11, 32'h0);
        issue(4'd8, 32'h22, 32'h0);
        directed(4'd4, 32'd7, 32'd0, 32'h11, 32'h22);
        check_rd();

        // MTLO pulsed on the second busy cycle must be ignored.
        issue(4'd1, 32'h1234, 32'h5678);
        @(posedge clk); #1;
        md.start = 1'b1; md.op = 4'd8; md.A = 32'h55;
        @(posedge clk); #1;
        md.start = 1'b0; md.op = 4'd0;
        wait_idle();
        check("mt_ignored_lo", md.LO, 32'h1234 * 32'h5678);

        // Reset on busy cycle 4 of a DIV discards it.
        issue(4'd3, 32'd100, 32'd7);
        void'(sb_q.pop_back());
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'b0, md.busy}, 32'd0);
        check("abort_hi", md.HI, 32'd0);
        check("abort_lo", md.LO, 32'd0);
        hi_m = 0; lo_m = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(4'd1, 32'hFFFFFFFD, 32'd9);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            issue(o, a, b);
            if (o <= 4'd4) wait_idle();
            check_rd();
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
